// File: rtl/mvm_result_serializer.sv
// Result serializer for the MVM engine: buffers whole parallel result sets
// in a small set-wide FIFO and streams them out one word per transfer,
// lane 0 first. Sets arriving while the FIFO is full and not popping are
// dropped, and a sticky overflow flag records the loss.
module mvm_result_serializer #(
  parameter int OWIDTH     = 32,
  parameter int NUM_OLANES = 8,
  parameter int DEPTH      = 4,
  parameter int LANEW      = $clog2(NUM_OLANES),
  parameter int CNTW       = $clog2(DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [0:NUM_OLANES-1][OWIDTH-1:0]     i_result,
  input  logic                                  i_valid,
  output logic [OWIDTH-1:0]                     o_data,
  output logic [LANEW-1:0]                      o_lane,
  output logic                                  o_last,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [CNTW-1:0]                       o_count,
  output logic                                  o_full,
  output logic                                  o_overflow
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [LANEW-1:0] LANE_LAST = LANEW'(NUM_OLANES - 1);
  localparam logic [CNTW-1:0]  DEPTH_C   = CNTW'(DEPTH);

  typedef logic [0:NUM_OLANES-1][OWIDTH-1:0] set_t;

  set_t             mem_q [DEPTH];
  logic [PTRW-1:0]  wptr_q, wptr_d;
  logic [PTRW-1:0]  rptr_q, rptr_d;
  logic [LANEW-1:0] lane_q, lane_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;

  logic valid_s, xfer_s, pop_s, push_s, drop_s;

  // Handshake decode: a push is allowed whenever a slot is free or the head
  // slot is released on this same edge, so the head is never overwritten.
  always_comb begin
    valid_s = (count_q != '0);
    xfer_s  = valid_s && i_ready;
    pop_s   = xfer_s && (lane_q == LANE_LAST);
    push_s  = i_valid && ((count_q != DEPTH_C) || pop_s);
    drop_s  = i_valid && !push_s;
  end

  // Next-state for pointers, lane counter, occupancy and overflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    lane_d  = lane_q;
    count_d = count_q;
    ovf_d   = ovf_q | drop_s;
    if (push_s) begin
      wptr_d = wptr_q + PTRW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (xfer_s) begin
      if (pop_s) begin
        lane_d = '0;
        rptr_d = rptr_q + PTRW'(1);
      end else begin
        lane_d = lane_q + LANEW'(1);
      end
    end else begin
      lane_d = lane_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset; a reset abandons any
  // partially drained set and clears the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      lane_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      lane_q  <= lane_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Set storage: written whole on an accepted push; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wptr_q] <= i_result;
    end
  end

  // Outputs depend only on registers; idle outputs are forced to zero.
  always_comb begin
    o_valid    = valid_s;
    o_count    = count_q;
    o_full     = (count_q == DEPTH_C);
    o_overflow = ovf_q;
    if (valid_s) begin
      o_data = mem_q[rptr_q][lane_q];
      o_lane = lane_q;
      o_last = (lane_q == LANE_LAST);
    end else begin
      o_data = '0;
      o_lane = '0;
      o_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_mvm_result_serializer.sv
// Self-checking bench for mvm_result_serializer. The reference model is a
// flat queue of words still owed downstream; occupancy, head lane and the
// expected output word are derived from its length with plain arithmetic.
module tb_mvm_result_serializer;

  localparam int OW = 32;
  localparam int N  = 8;
  localparam int D  = 4;

  logic                 clk;
  logic                 rst;
  logic [0:N-1][OW-1:0] i_result;
  logic                 i_valid;
  logic [OW-1:0]        o_data;
  logic [2:0]           o_lane;
  logic                 o_last;
  logic                 o_valid;
  logic                 i_ready;
  logic [2:0]           o_count;
  logic                 o_full;
  logic                 o_overflow;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [OW-1:0] wq[$];
  bit            m_ovf = 1'b0;
  bit            m_valid, m_last, m_full;
  logic [OW-1:0] m_data;
  logic [2:0]    m_lane, m_count;

  logic [OW-1:0] got[$];

  mvm_result_serializer #(.OWIDTH(OW), .NUM_OLANES(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_valid(i_valid),
    .o_data(o_data), .o_lane(o_lane), .o_last(o_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_count(o_count), .o_full(o_full),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int head_lane(int sz);
    return (sz % N == 0) ? 0 : N - (sz % N);
  endfunction

  // Advance one clock: update the model with the inputs seen at the edge,
  // then stop on the following negedge with the expected outputs computed.
  task automatic tick();
    int sz, cnt, ln;
    bit xfer, pop, push;
    @(posedge clk);
    if (!rst) begin
      wq.delete();
      m_ovf = 1'b0;
    end else begin
      sz   = wq.size();
      ln   = head_lane(sz);
      cnt  = (sz + N - 1) / N;
      xfer = (sz > 0) && i_ready;
      pop  = xfer && (ln == N - 1);
      push = i_valid && ((cnt < D) || pop);
      if (xfer) void'(wq.pop_front());
      if (push) begin
        for (int k = 0; k < N; k++) wq.push_back(i_result[k]);
      end else if (i_valid) begin
        m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    sz      = wq.size();
    m_valid = (sz != 0);
    m_data  = m_valid ? wq[0] : '0;
    m_lane  = m_valid ? 3'(head_lane(sz)) : 3'd0;
    m_last  = m_valid && (head_lane(sz) == N - 1);
    m_count = 3'((sz + N - 1) / N);
    m_full  = ((sz + N - 1) / N == D);
  endtask

  task automatic mkset(input int base);
    for (int k = 0; k < N; k++) i_result[k] = OW'(base + k);
  endtask

  task automatic rndset();
    for (int k = 0; k < N; k++) i_result[k] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_valid = 1'b1; i_ready = 1'b1; rndset();
    tick(); tick();
    checks++;
    if ({o_valid, o_data, o_lane, o_last, o_count, o_full, o_overflow} !== 41'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h l=%0d last=%b c=%0d f=%b ov=%b want all zero",
               o_valid, o_data, o_lane, o_last, o_count, o_full, o_overflow);
    end
    rst = 1'b1; i_valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_ignores_valid got v=%b c=%0d want v=0 c=0", o_valid, o_count);
    end
  endtask

  task automatic test_single();
    i_ready = 1'b1; i_valid = 1'b1; mkset(10);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== OW'(10 + k) || o_lane !== 3'(k) ||
          o_last !== (k == N - 1) || o_count !== 3'd1) begin
        failures++;
        $display("FAIL single_word%0d got v=%b d=%0d l=%0d last=%b c=%0d want v=1 d=%0d l=%0d last=%b c=1",
                 k, o_valid, o_data, o_lane, o_last, o_count, 10 + k, k, k == N - 1);
      end
      tick();
    end
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      failures++;
      $display("FAIL single_empty got v=%b c=%0d want v=0 c=0", o_valid, o_count);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] pd;
    logic [2:0]    pl;
    bit            hold;
    int            delivered = 0;
    logic [OW-1:0] exp_w[N];
    i_ready = 1'b0; i_valid = 1'b1; rndset();
    for (int k = 0; k < N; k++) exp_w[k] = i_result[k];
    tick();
    i_valid = 1'b0;
    hold = 1'b0; pd = '0; pl = '0;
    for (int c = 0; c < 40 && delivered < N; c++) begin
      i_ready = (c % 3 == 0);
      checks++;
      if (o_valid !== 1'b1 || (hold && (o_data !== pd || o_lane !== pl)) ||
          o_data !== exp_w[delivered] || o_lane !== 3'(delivered)) begin
        failures++;
        $display("FAIL backpressure_c%0d got v=%b d=%h l=%0d want v=1 d=%h l=%0d", c,
                 o_valid, o_data, o_lane, exp_w[delivered], delivered);
      end
      hold = !i_ready; pd = o_data; pl = o_lane;
      if (i_ready) delivered++;
      tick();
    end
    checks++;
    if (delivered != N || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_done got delivered=%0d v=%b want 8 v=0", delivered, o_valid);
    end
    i_ready = 1'b0;
  endtask

  task automatic test_push_full_pop();
    int bases[4] = '{600, 700, 800, 1000};
    i_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin i_valid = 1'b1; mkset(bases[s]); tick(); end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < N - 1; k++) tick();
    checks++;
    if (o_lane !== 3'd7 || o_count !== 3'd4 || o_full !== 1'b1) begin
      failures++;
      $display("FAIL pfp_setup got l=%0d c=%0d f=%b want l=7 c=4 f=1", o_lane, o_count, o_full);
    end
    i_valid = 1'b1; mkset(900);
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_count !== 3'd4 || o_overflow !== 1'b0 || o_data !== OW'(700) || o_lane !== 3'd0) begin
      failures++;
      $display("FAIL pfp_accept got c=%0d ov=%b d=%0d l=%0d want c=4 ov=0 d=700 l=0",
               o_count, o_overflow, o_data, o_lane);
    end
    got.delete();
    for (int c = 0; c < 40 && o_valid; c++) begin
      got.push_back(o_data);
      checks++;
      if ({o_valid, o_data, o_lane, o_last, o_count, o_full, o_overflow} !==
          {m_valid, m_data, m_lane, m_last, m_count, m_full, m_ovf}) begin
        failures++;
        $display("FAIL pfp_model got d=%0d l=%0d c=%0d want d=%0d l=%0d c=%0d",
                 o_data, o_lane, o_count, m_data, m_lane, m_count);
      end
      tick();
    end
    checks++;
    if (got.size() != 32) begin
      failures++;
      $display("FAIL pfp_len got %0d want 32", got.size());
    end else begin
      for (int k = 0; k < N; k++) begin
        checks++;
        if (got[24 + k] !== OW'(900 + k)) begin
          failures++;
          $display("FAIL pfp_tail%0d got %0d want %0d", k, got[24 + k], 900 + k);
        end
      end
    end
  endtask

  task automatic test_fill_overflow();
    int bases[5] = '{100, 200, 300, 400, 500};
    i_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin i_valid = 1'b1; mkset(bases[s]); tick(); end
    i_valid = 1'b0;
    checks++;
    if (o_count !== 3'd4 || o_full !== 1'b1 || o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL fill_state got c=%0d f=%b ov=%b want c=4 f=1 ov=1", o_count, o_full, o_overflow);
    end
    i_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 40 && o_valid; c++) begin
      got.push_back(o_data);
      tick();
    end
    checks++;
    if (got.size() != 32) begin
      failures++;
      $display("FAIL fill_len got %0d want 32", got.size());
    end
    for (int j = 0; j < got.size() && j < 32; j++) begin
      checks++;
      if (got[j] !== OW'(bases[j / N] + j % N)) begin
        failures++;
        $display("FAIL fill_word%0d got %0d want %0d", j, got[j], bases[j / N] + j % N);
      end
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    i_valid = 1'b1; rndset(); tick();
    rndset(); tick();
    i_valid = 1'b0; i_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got v=%b c=%0d ov=%b want 0 0 0", o_valid, o_count, o_overflow);
    end
    i_valid = 1'b1; mkset(50);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== OW'(50 + k) || o_lane !== 3'(k)) begin
        failures++;
        $display("FAIL reset_mid_word%0d got v=%b d=%0d l=%0d want v=1 d=%0d l=%0d",
                 k, o_valid, o_data, o_lane, 50 + k, k);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      i_valid = (c % N == 0);
      rndset();
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_count > 3'd1 || o_overflow !== 1'b0 || o_data !== m_data) begin
        failures++;
        $display("FAIL b2b_c%0d got v=%b c=%0d ov=%b d=%h want v=1 c<=1 ov=0 d=%h",
                 c, o_valid, o_count, o_overflow, o_data, m_data);
      end
    end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) == 0);
      i_ready = ($urandom_range(0, 2) != 0);
      rndset();
      tick();
      checks++;
      if ({o_valid, o_data, o_lane, o_last, o_count, o_full, o_overflow} !==
          {m_valid, m_data, m_lane, m_last, m_count, m_full, m_ovf}) begin
        failures++;
        $display("FAIL random_c%0d got v=%b d=%h l=%0d last=%b c=%0d f=%b ov=%b want v=%b d=%h l=%0d last=%b c=%0d f=%b ov=%b",
                 c, o_valid, o_data, o_lane, o_last, o_count, o_full, o_overflow,
                 m_valid, m_data, m_lane, m_last, m_count, m_full, m_ovf);
      end
    end
    i_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_result = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_push_full_pop();
    test_fill_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvm_result_serializer.md
# mvm_result_serializer

Downstream stage of the matrix-vector multiply engine. It captures each parallel result set (NUM_OLANES words presented together for one cycle on a valid pulse) into a small set-wide FIFO. It then drains each set as a single-word valid/ready stream in lane order 0..NUM_OLANES-1. The MVM cannot stall, so this block absorbs bursts of result sets and flags any set it has to drop.

## Interface
Parameters:
- OWIDTH, 32, width of one lane result and of the output word
- NUM_OLANES, 8, lanes per result set
- DEPTH, 4, result sets buffered; power of two, ≥2
- LANEW, $clog2(NUM_OLANES), lane index width
- CNTW, $clog2(DEPTH+1), occupancy count width

Ports:
- clk  input  1  sole clock; all logic on posedge
- rst  input  1  reset, synchronous, active-low (rst==0 resets at posedge clk)
- i_result  input  OWIDTH × [0:NUM_OLANES-1]  parallel result set from MVM
- i_valid  input  1  single-cycle pulse, i_result valid this cycle
- o_data  output  OWIDTH  current output word
- o_lane  output  LANEW  lane index of o_data
- o_last  output  1  o_data is lane NUM_OLANES-1 of its set
- o_valid  output  1  o_data/o_lane/o_last valid
- i_ready  input  1  downstream accepts word when o_valid&&i_ready
- o_count  output  CNTW  result sets currently stored (including partially drained head)
- o_full  output  1  o_count==DEPTH
- o_overflow  output  1  sticky: a set was dropped; cleared only by reset

## Operation
- Storage: DEPTH entries × (NUM_OLANES·OWIDTH) bits, write pointer, read pointer (log2 DEPTH bits, natural wrap), lane counter, count register. All are registered.
- Push: at a posedge with i_valid=1, all NUM_OLANES words are written to entry[wptr]; wptr++, count++. This happens only if count<DEPTH, or a pop occurs in the same cycle.
- Drop: i_valid=1 with count==DEPTH and no pop in the same cycle. The set is discarded, pointers and count are unchanged, and o_overflow←1.
- Output (combinational from registers): o_valid = (count≠0).
  - o_data = entry[rptr][lane].
  - o_lane = lane.
  - o_last = o_valid && lane==NUM_OLANES-1.
  - When o_valid=0: o_data=0, o_lane=0, o_last=0.
- Transfer: o_valid&&i_ready.
  - If lane<NUM_OLANES-1: lane++.
  - Else (pop): lane←0, rptr++, count--.
- Simultaneous push and pop: count is unchanged, both pointers advance, and the push is accepted even when full.
- The head entry is never overwritten while it is being drained; a push only targets entry[wptr] when a slot is free or freed this cycle.
- Stream rules:
  - Once o_valid=1 it stays 1 with o_data/o_lane/o_last stable until the transfer.
  - Words leave strictly in arrival order of sets and in lane order within a set.
  - There is no gap between sets when i_ready is held high.
- Reset (rst=0): count=0, wptr=rptr=0, lane=0, o_overflow=0. Hence o_valid=0, o_data=0, o_lane=0, o_last=0, o_full=0, o_count=0. Storage contents are not reset.
- Reset mid-drain abandons the partial set; i_valid during reset is ignored.

## Timing
- Push at posedge t ⇒ o_valid=1 (if previously empty) with lane 0 during cycle t+1.
- Throughput: 1 word/cycle. A full set drains in NUM_OLANES cycles with i_ready held high.
- o_count/o_full update the cycle after the push/pop edge. o_overflow rises the cycle after the dropping edge.
- There is no combinational path from i_valid or i_result to any output. i_ready feeds only registered state, so no ready→valid combinational path exists.

## Test plan
- Single set: rst released, i_result={10,11,…,17}, i_valid pulse at t, i_ready=1 -> o_valid t+1..t+8. o_data 10..17, o_lane 0..7, o_last only with 17, o_count 1→0 after last transfer.
- Backpressure: one set, i_ready toggles 1,0,0,1,… -> o_data/o_lane held stable during every low i_ready cycle, all 8 words delivered once in order, o_valid never drops mid-set.
- Fill/overflow: i_ready=0, 5 pulses with sets base 100,200,300,400,500 (lane k = base+k) -> o_count=4, o_full=1, o_overflow=1. Then with i_ready=1, 32 words 100..107,200..207,300..307,400..407 appear and 500 never appears.
- Push while full with pop: count=4, i_ready=1, head on lane 7. i_valid with set base 900 on the same edge as the lane-7 transfer -> accepted, o_count stays 4, o_overflow stays 0, set 900 later drained after the other three.
- Reset mid-stream: after 3 words of a set and one more set queued, assert rst=0 for one edge -> next cycle o_valid=0, o_count=0, o_overflow=0. A new set 50..57 then drains from lane 0 with o_data 50..57.
- Back-to-back sets: pulses every 8 cycles, i_ready=1 -> continuous o_valid, o_count never exceeds 1, no overflow.
